// File: rtl/sync_output_mux_pkg.sv
// Shared definitions for the per-bit synchronous output multiplexer.
//   lane_state_e : per-lane switch FSM encoding (STABLE / PENDING)
//   sel_width()  : select-field width for a given number of sources
//   SEL_W        : select width for the default two-source configuration
package sync_output_mux_pkg;

  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } lane_state_e;

  // A single-source mux still needs a 1-bit select field.
  function automatic int sel_width(input int num_inputs);
    return (num_inputs > 1) ? $clog2(num_inputs) : 1;
  endfunction

  localparam int DEFAULT_NUM_INPUTS = 2;
  localparam int SEL_W = sel_width(DEFAULT_NUM_INPUTS);

endpackage

// File: rtl/sync_mux_lane.sv
// One output bit of the synchronous output multiplexer.
// Holds the active/target source selection, the idle-run counter, the
// STABLE/PENDING switch FSM and the registered output bit.
//   sys_clk, rst : clock, synchronous active-high reset
//   src_bits     : this bit of every source
//   sel_req      : requested source index, sampled when req_valid is high
//   req_valid    : request strobe
//   force_req    : switch immediately without waiting for idle
//   out_bit      : registered output (1-cycle latency)
//   active_sel   : source currently driving the output
//   pending      : a switch is waiting for its safe point
//   done         : 1-cycle pulse when active_sel changes
//   sel_err      : 1-cycle pulse on an out-of-range request
module sync_mux_lane
  import sync_output_mux_pkg::*;
#(
  parameter int   NUM_INPUTS  = 2,
  parameter int   IDLE_CYCLES = 3,
  parameter int   LANE_SEL_W  = 1,
  parameter logic IDLE_BIT    = 1'b1
) (
  input  logic                  sys_clk,
  input  logic                  rst,
  input  logic [NUM_INPUTS-1:0] src_bits,
  input  logic [LANE_SEL_W-1:0] sel_req,
  input  logic                  req_valid,
  input  logic                  force_req,
  output logic                  out_bit,
  output logic [LANE_SEL_W-1:0] active_sel,
  output logic                  pending,
  output logic                  done,
  output logic                  sel_err
);

  localparam int CNT_W = $clog2(IDLE_CYCLES + 1);

  lane_state_e           state_q, state_d;
  logic [LANE_SEL_W-1:0] active_q, active_d;
  logic [LANE_SEL_W-1:0] target_q, target_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  out_q, out_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic idx_ok;
  logic req_ok;
  logic idle;

  assign idx_ok = (int'(sel_req) < NUM_INPUTS);
  assign req_ok = req_valid && idx_ok;
  // Safe point: both the outgoing and the incoming source sit at idle.
  assign idle   = (src_bits[active_q] == IDLE_BIT) && (src_bits[target_q] == IDLE_BIT);

  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    out_d    = src_bits[active_q];
    done_d   = 1'b0;
    err_d    = req_valid && !idx_ok;

    // An out-of-range request is treated as if no request was made.
    if (req_ok && force_req) begin
      state_d = STABLE;
      cnt_d   = '0;
      if (sel_req != active_q) begin
        active_d = sel_req;
        done_d   = 1'b1;
      end
    end else if (req_ok) begin
      cnt_d = '0;
      if (sel_req == active_q) begin
        // Requesting the current source is a no-op when stable and a
        // cancel when a switch is pending.
        state_d = STABLE;
      end else begin
        target_d = sel_req;
        state_d  = PENDING;
      end
    end else if (state_q == PENDING) begin
      if (force_req) begin
        active_d = target_q;
        done_d   = 1'b1;
        state_d  = STABLE;
        cnt_d    = '0;
      end else if (idle) begin
        if (cnt_q == CNT_W'(IDLE_CYCLES - 1)) begin
          active_d = target_q;
          done_d   = 1'b1;
          state_d  = STABLE;
          cnt_d    = '0;
        end else if (cnt_q != CNT_W'(IDLE_CYCLES)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else begin
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q  <= STABLE;
      active_q <= '0;
      target_q <= '0;
      cnt_q    <= '0;
      out_q    <= IDLE_BIT;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign out_bit    = out_q;
  assign active_sel = active_q;
  assign pending    = (state_q == PENDING);
  assign done       = done_q;
  assign sel_err    = err_q;

endmodule

// File: rtl/sync_output_mux.sv
// WIDTH-bit output multiplexer where every bit independently selects one
// of NUM_INPUTS sources and only switches once both old and new source
// have been idle for IDLE_CYCLES cycles (or immediately when forced).
//   sys_clk, rst   : clock, synchronous active-high reset
//   in_lines       : source i at [i*WIDTH +: WIDTH]
//   select_req     : requested source of bit b at [b*SW +: SW]
//   req_valid      : per-bit request strobe
//   force_req      : per-bit immediate switch
//   out_line       : registered mux output
//   active_select  : current source per bit
//   switch_pending : per-bit waiting-for-safe-point flag
//   switch_done    : per-bit pulse on active_select change
//   sel_error      : per-bit pulse on an invalid requested index
module sync_output_mux
  import sync_output_mux_pkg::*;
#(
  parameter int               WIDTH       = 4,
  parameter int               NUM_INPUTS  = 2,
  parameter int               IDLE_CYCLES = 3,
  parameter logic [WIDTH-1:0] IDLE_LEVEL  = {WIDTH{1'b1}},
  localparam int              SW          = sel_width(NUM_INPUTS)
) (
  input  logic                        sys_clk,
  input  logic                        rst,
  input  logic [NUM_INPUTS*WIDTH-1:0] in_lines,
  input  logic [WIDTH*SW-1:0]         select_req,
  input  logic [WIDTH-1:0]            req_valid,
  input  logic [WIDTH-1:0]            force_req,
  output logic [WIDTH-1:0]            out_line,
  output logic [WIDTH*SW-1:0]         active_select,
  output logic [WIDTH-1:0]            switch_pending,
  output logic [WIDTH-1:0]            switch_done,
  output logic [WIDTH-1:0]            sel_error
);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lane
    // Gather bit gi of every source into one vector for this lane.
    logic [NUM_INPUTS-1:0] lane_src;
    for (genvar si = 0; si < NUM_INPUTS; si++) begin : g_src
      assign lane_src[si] = in_lines[si*WIDTH + gi];
    end

    sync_mux_lane #(
      .NUM_INPUTS (NUM_INPUTS),
      .IDLE_CYCLES(IDLE_CYCLES),
      .LANE_SEL_W (SW),
      .IDLE_BIT   (IDLE_LEVEL[gi])
    ) u_lane (
      .sys_clk   (sys_clk),
      .rst       (rst),
      .src_bits  (lane_src),
      .sel_req   (select_req[gi*SW +: SW]),
      .req_valid (req_valid[gi]),
      .force_req (force_req[gi]),
      .out_bit   (out_line[gi]),
      .active_sel(active_select[gi*SW +: SW]),
      .pending   (switch_pending[gi]),
      .done      (switch_done[gi]),
      .sel_err   (sel_error[gi])
    );
  end

endmodule

// File: tb/tb_sync_output_mux.sv
module tb_sync_output_mux;

  localparam int W  = 4;
  localparam int NI = 3;
  localparam int IC = 3;
  localparam int SW = 2;

  typedef struct {
    logic [W-1:0]    out;
    logic [W*SW-1:0] act;
    logic [W-1:0]    pend;
    logic [W-1:0]    done;
    logic [W-1:0]    err;
  } exp_t;

  logic              sys_clk = 1'b0;
  logic              rst = 1'b1;
  logic [NI*W-1:0]   in_lines = '0;
  logic [W*SW-1:0]   select_req = '0;
  logic [W-1:0]      req_valid = '0;
  logic [W-1:0]      force_req = '0;
  logic [W-1:0]      out_line;
  logic [W*SW-1:0]   active_select;
  logic [W-1:0]      switch_pending;
  logic [W-1:0]      switch_done;
  logic [W-1:0]      sel_error;

  int tests = 0;
  int fails = 0;
  exp_t exp_q[$];

  // Reference state per bit: current source, wanted source, whether a
  // switch is outstanding and how many idle cycles in a row were seen.
  int m_act[W];
  int m_tgt[W];
  int m_run[W];
  bit m_pend[W];

  sync_output_mux #(
    .WIDTH(W), .NUM_INPUTS(NI), .IDLE_CYCLES(IC), .IDLE_LEVEL(4'b1111)
  ) dut (
    .sys_clk(sys_clk), .rst(rst), .in_lines(in_lines), .select_req(select_req),
    .req_valid(req_valid), .force_req(force_req), .out_line(out_line),
    .active_select(active_select), .switch_pending(switch_pending),
    .switch_done(switch_done), .sel_error(sel_error)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic model_step(input logic r, input logic [NI*W-1:0] lines,
                            input logic [W*SW-1:0] sel, input logic [W-1:0] rv,
                            input logic [W-1:0] fr, output exp_t e);
    e.out = '1; e.act = '0; e.pend = '0; e.done = '0; e.err = '0;
    for (int b = 0; b < W; b++) begin
      int s;
      if (r) begin
        m_act[b] = 0; m_tgt[b] = 0; m_run[b] = 0; m_pend[b] = 0;
        continue;
      end
      s = int'(sel[b*SW +: SW]);
      e.out[b] = lines[m_act[b]*W + b];
      if (rv[b] && s >= NI) begin
        e.err[b] = 1'b1;
      end else if (rv[b] && fr[b]) begin
        if (s != m_act[b]) begin m_act[b] = s; e.done[b] = 1'b1; end
        m_pend[b] = 0; m_run[b] = 0;
      end else if (rv[b]) begin
        m_run[b] = 0;
        if (s == m_act[b]) m_pend[b] = 0;
        else begin m_pend[b] = 1; m_tgt[b] = s; end
      end else if (m_pend[b] && fr[b]) begin
        m_act[b] = m_tgt[b]; e.done[b] = 1'b1; m_pend[b] = 0; m_run[b] = 0;
      end else if (m_pend[b]) begin
        if (lines[m_act[b]*W + b] && lines[m_tgt[b]*W + b]) m_run[b]++;
        else m_run[b] = 0;
        if (m_run[b] == IC) begin
          m_act[b] = m_tgt[b]; e.done[b] = 1'b1; m_pend[b] = 0; m_run[b] = 0;
        end
      end
    end
    for (int b = 0; b < W; b++) begin
      e.act[b*SW +: SW] = SW'(m_act[b]);
      e.pend[b] = m_pend[b];
    end
  endtask

  task automatic drive(input logic r, input logic [NI*W-1:0] lines,
                       input logic [W*SW-1:0] sel, input logic [W-1:0] rv,
                       input logic [W-1:0] fr);
    exp_t e;
    @(negedge sys_clk);
    rst = r; in_lines = lines; select_req = sel; req_valid = rv; force_req = fr;
    model_step(r, lines, sel, rv, fr, e);
    exp_q.push_back(e);
  endtask

  function automatic logic [W*SW-1:0] sel_one(input int b, input int v);
    logic [W*SW-1:0] s;
    s = '0;
    s[b*SW +: SW] = SW'(v);
    return s;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, got, want, $time);
    end
  endtask

  // Monitor: every cycle the DUT presents a full set of outputs.
  initial begin
    exp_t e;
    forever begin
      @(posedge sys_clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("out_line", 32'(out_line), 32'(e.out));
        check("active_select", 32'(active_select), 32'(e.act));
        check("switch_pending", 32'(switch_pending), 32'(e.pend));
        check("switch_done", 32'(switch_done), 32'(e.done));
        check("sel_error", 32'(sel_error), 32'(e.err));
        $display("[TB] t=%0t out=%h act=%h pend=%h done=%h err=%h", $time,
                 out_line, active_select, switch_pending, switch_done, sel_error);
      end
    end
  end

  initial begin
    logic [NI*W-1:0] ones;
    logic [NI*W-1:0] l;
    logic [W*SW-1:0] sel;
    logic [W-1:0]    rv;
    logic [W-1:0]    fr;
    int              budget;
    ones = '1;

    // Reset with all sources low, then release.
    drive(1, '0, '0, '0, '0);
    drive(1, '0, '0, '0, '0);
    drive(0, '0, '0, '0, '0);
    drive(0, '0, '0, '0, '0);

    // Idle-gated switch of bit 0 to source 1.
    drive(0, ones, '0, '0, '0);
    drive(0, ones, sel_one(0, 1), 4'b0001, '0);
    repeat (5) drive(0, ones, '0, '0, '0);

    // Bit 2 to source 1 while source 1 bit 2 glitches low once.
    drive(0, ones, sel_one(2, 1), 4'b0100, '0);
    drive(0, ones, '0, '0, '0);
    drive(0, ones, '0, '0, '0);
    drive(0, ones & ~(NI*W)'(12'h040), '0, '0, '0);
    repeat (5) drive(0, ones, '0, '0, '0);

    // Forced switch of bit 3 while its current source is busy.
    drive(0, ones & ~(NI*W)'(12'h008), sel_one(3, 1), 4'b1000, 4'b1000);
    repeat (2) drive(0, ones, '0, '0, '0);

    // Cancel a pending switch on bit 1, then reset in the middle of one.
    drive(0, ones, sel_one(1, 1), 4'b0010, '0);
    drive(0, ones, '0, '0, '0);
    drive(0, ones, sel_one(1, 0), 4'b0010, '0);
    repeat (4) drive(0, ones, '0, '0, '0);
    drive(0, ones, sel_one(1, 1), 4'b0010, '0);
    drive(0, ones, '0, '0, '0);
    drive(1, ones, '0, '0, '0);
    repeat (4) drive(0, ones, '0, '0, '0);

    // Out-of-range index, then a switch to the third source.
    drive(0, ones, sel_one(0, 3), 4'b0001, '0);
    drive(0, ones, sel_one(0, 2), 4'b0001, '0);
    repeat (5) drive(0, ones, '0, '0, '0);

    // Randomised traffic: lines mostly idle, sparse requests and forces.
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < NI*W; i++) l[i] = ($urandom_range(0, 5) != 0);
      for (int b = 0; b < W; b++) begin
        int s;
        rv[b] = ($urandom_range(0, 7) == 0);
        fr[b] = ($urandom_range(0, 11) == 0);
        s = $urandom_range(0, 3);
        if (s == 3 && m_pend[b]) s = $urandom_range(0, 2);
        sel[b*SW +: SW] = SW'(s);
      end
      drive(($urandom_range(0, 99) == 0), l, sel, rv, fr);
    end
    drive(0, ones, '0, '0, '0);

    budget = 0;
    while (exp_q.size() > 0 && budget < 10) begin
      @(posedge sys_clk);
      budget++;
    end
    #2;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
